// File: rtl/arb_rr4_pkg.sv
// Shared constants, FSM state type and the round-robin winner function for arb_rr4.
package arb_pkg;

    localparam int ARB_N_REQ = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Search order is last+1, last+2, last+3, last (mod 4); returns last when req is empty.
    function automatic logic [ARB_IDX_W-1:0] rr_next(
        input logic [ARB_N_REQ-1:0] req,
        input logic [ARB_IDX_W-1:0] last
    );
        logic [ARB_IDX_W-1:0] cand;
        logic [ARB_IDX_W-1:0] win;
        logic                 found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= ARB_N_REQ; i++) begin
            cand = last + ARB_IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_rr4_if.sv
// Request/grant bundle for arb_rr4, plus the arbiter's FSM state and pointer for observation.
interface arb_rr4_if;
    import arb_pkg::*;

    logic [ARB_N_REQ-1:0] req;
    logic [ARB_N_REQ-1:0] gnt;
    logic [ARB_IDX_W-1:0] gnt_idx;
    logic                 gnt_valid;
    logic                 timeout;
    arb_state_e           dbg_state;
    logic [ARB_IDX_W-1:0] dbg_last;

    // Handshake: a client holds req high for as long as it wants the resource; the grant it
    // sees is registered, and ownership lasts until the owner drops req (or the hold limit hits).
    modport master (
        output req,
        input  gnt, gnt_idx, gnt_valid, timeout, dbg_state, dbg_last
    );

    modport slave (
        input  req,
        output gnt, gnt_idx, gnt_valid, timeout, dbg_state, dbg_last
    );

endinterface

// File: rtl/dec2to4_onehot.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4_onehot (
    input  logic [1:0] idx_i,
    input  logic       en_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o        = 4'b0000;
        onehot_o[idx_i] = en_i;
    end

endmodule

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional hold-timeout re-arbitration is enabled by defining ARB_TIMEOUT_EN.
module arb_rr4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    arb_rr4_if.slave   bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 16) begin : g_bad_max_hold
        $error("arb_rr4: MAX_HOLD must be in 2..16");
    end

    arb_state_e           state_q, state_d;
    logic [ARB_IDX_W-1:0] idx_q, idx_d;
    logic [ARB_IDX_W-1:0] last_q, last_d;
    logic [ARB_N_REQ-1:0] gnt_q, gnt_d;
    logic [ARB_IDX_W-1:0] rr_win;
    logic                 grant_new;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    assign rr_win = rr_next(bus.req, last_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        grant_new = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) grant_new = 1'b1;
            end
            GRANT: begin
                if (bus.req[idx_q]) begin
`ifdef ARB_TIMEOUT_EN
                    // last_q equals the owner here, so rr_win puts the owner last.
                    if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        grant_new = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end else if (|bus.req) begin
                    grant_new = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_new) begin
            state_d = GRANT;
            idx_d   = rr_win;
            last_d  = rr_win;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
    end

    // Decode the next owner so the one-hot grant can be registered alongside the index.
    dec2to4_onehot u_dec (
        .idx_i    (idx_d),
        .en_i     (state_d == GRANT),
        .onehot_o (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= 2'd3;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.dbg_state = state_q;
    assign bus.dbg_last  = last_q;

endmodule
